// File: rtl/lal_pkg.sv
// Shared types and constants for the thermometer stage sequencer.
package lal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STAGES_DEF = 9;
  localparam int CMP_W_DEF  = 4;

  // Width needed to hold a count in the range 0..stages inclusive.
  function automatic int cnt_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/lal_mag_cmp.sv
// Registered unsigned magnitude comparator; one cycle of latency.
module lal_mag_cmp #(
  parameter int CMP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMP_W-1:0] a,
  input  logic [CMP_W-1:0] b,
  output logic             gt,
  output logic             eq
);

  // Capture the compare result of this cycle's operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt <= 1'b0;
      eq <= 1'b0;
    end else begin
      gt <= (a > b);
      eq <= (a == b);
    end
  end

endmodule

// File: rtl/lal_thermo_seq.sv
// Thermometer stage sequencer with compare-gated advance.
//
//   state | meaning
//   ------+-------------------------------------------------------
//   IDLE  | therm/count cleared, waiting for start_i
//   RUN   | filling stages, one bit per qualified advance
//   DONE  | single-cycle completion strobe, therm all ones
module lal_thermo_seq
  import lal_pkg::*;
#(
  parameter  int STAGES = STAGES_DEF,
  parameter  int CMP_W  = CMP_W_DEF,
  localparam int CNT_W  = cnt_w(STAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              advance_i,
  input  logic              hold_i,
  input  logic              abort_i,
  input  logic              gate_en_i,
  input  logic [CMP_W-1:0]  a_i,
  input  logic [CMP_W-1:0]  b_i,
  output logic [STAGES-1:0] therm_o,
  output logic [STAGES-1:0] front_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cmp_gt_o,
  output logic              cmp_eq_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(STAGES);

  state_t            state, state_n;
  logic [STAGES-1:0] therm, therm_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              cmp_ge;
  logic              adv_q;

  lal_mag_cmp #(.CMP_W(CMP_W)) u_cmp (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_i),
    .b     (b_i),
    .gt    (cmp_gt_o),
    .eq    (cmp_eq_o)
  );

  // The gate uses the previous cycle's operands, as seen through the register.
  assign cmp_ge = cmp_gt_o | cmp_eq_o;
  assign adv_q  = advance_i & ~hold_i & (~gate_en_i | cmp_ge);

  // State, thermometer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      therm <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      therm <= therm_n;
      count <= count_n;
    end
  end

  // Next-state logic; abort dominates, hold is folded into adv_q.
  always_comb begin
    state_n = state;
    therm_n = therm;
    count_n = count;
    case (state)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_n = RUN;
          therm_n = STAGES'(1);
          count_n = CNT_W'(1);
        end
      end
      RUN: begin
        if (abort_i) begin
          state_n = IDLE;
          therm_n = '0;
          count_n = '0;
        end else if (adv_q) begin
          if (count < FULL) begin
            therm_n = {therm[STAGES-2:0], 1'b1};
            count_n = count + CNT_W'(1);
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        therm_n = '0;
        count_n = '0;
      end
      default: begin
        state_n = IDLE;
        therm_n = '0;
        count_n = '0;
      end
    endcase
  end

  // For a thermometer code the highest set bit is the one whose upper neighbour is clear.
  assign front_o = therm & ~(therm >> 1);
  assign therm_o = therm;
  assign count_o = count;
  assign busy_o  = (state == RUN);
  assign done_o  = (state == DONE);

  // The maintained counter must always agree with the thermometer fill.
  count_matches_therm: assert property (
    @(posedge clk) disable iff (!rst_n) count == CNT_W'($countones(therm))
  );

endmodule
